// File: rtl/dest_drain_arbiter_if.sv
// Bundles the destination-FIFO read side and the merged valid/ready output stream.
// master = arbiter side, slave = FIFOs plus downstream sink.
interface dest_drain_arbiter_if #(
  parameter int data_width = 6
);
  logic                  empty_fifo_D0;
  logic                  empty_fifo_D1;
  logic [data_width-1:0] data_out_D0;
  logic [data_width-1:0] data_out_D1;
  logic                  D0_pop;
  logic                  D1_pop;
  logic                  out_valid;
  logic                  out_ready;
  logic [data_width-1:0] out_data;
  logic                  out_dest;

  modport master (
    input  empty_fifo_D0, empty_fifo_D1, data_out_D0, data_out_D1, out_ready,
    output D0_pop, D1_pop, out_valid, out_data, out_dest
  );

  modport slave (
    output empty_fifo_D0, empty_fifo_D1, data_out_D0, data_out_D1, out_ready,
    input  D0_pop, D1_pop, out_valid, out_data, out_dest
  );
endinterface

// File: rtl/dest_drain_arbiter.sv
// Round-robin drain of the D0/D1 destination FIFOs into one tagged valid/ready stream,
// absorbing the 1-cycle FIFO read latency with a 2-entry output buffer.
module dest_drain_arbiter #(
  parameter int data_width = 6,
  parameter int cnt_width  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  dest_drain_arbiter_if.master bus,
  output logic [cnt_width-1:0] cnt_D0,
  output logic [cnt_width-1:0] cnt_D1,
  output logic                 idle_out
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_INIT   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_inflight;
  logic                  r_inflight_dest;
  logic                  r_last_d1;
  logic [1:0]            r_occ;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [data_width-1:0] r_buf_data [2];
  logic                  r_buf_dest [2];

  logic                  w_pop0;
  logic                  w_pop1;
  logic                  w_block_pop;
  logic                  w_hold_cnt;
  logic                  w_deliver;
  logic [2:0]            w_load;

  assign w_deliver  = (r_occ != 2'd0) && bus.out_ready;
  assign w_hold_cnt = init || (r_state == S_INIT);
  assign w_block_pop = !reset || w_hold_cnt;
  // A word leaving this cycle frees its slot, so a steady stream can pop every cycle.
  assign w_load = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_deliver};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pop0       = 1'b0;
    w_pop1       = 1'b0;
    if (!w_block_pop && (w_load < 3'd2)) begin
      if (!bus.empty_fifo_D0 && (bus.empty_fifo_D1 || r_last_d1)) begin
        w_pop0 = 1'b1;
      end else if (!bus.empty_fifo_D1) begin
        w_pop1 = 1'b1;
      end
    end
    case (r_state)
      S_IDLE: begin
        if (!bus.empty_fifo_D0 || !bus.empty_fifo_D1) begin
          w_state_next = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (bus.empty_fifo_D0 && bus.empty_fifo_D1 && !r_inflight && (r_occ == 2'd0)) begin
          w_state_next = S_IDLE;
        end
      end
      S_INIT:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (init) begin
      w_state_next = S_INIT;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_inflight      <= 1'b0;
      r_inflight_dest <= 1'b0;
      r_last_d1       <= 1'b1;
      r_occ           <= 2'd0;
      r_wr_ptr        <= 1'b0;
      r_rd_ptr        <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_buf_data[i] <= '0;
        r_buf_dest[i] <= 1'b0;
      end
    end else begin
      r_inflight <= w_pop0 || w_pop1;
      if (w_pop0 || w_pop1) begin
        r_inflight_dest <= w_pop1;
        r_last_d1       <= w_pop1;
      end
      // FIFO read data is valid the cycle after the pop.
      if (r_inflight) begin
        r_buf_data[r_wr_ptr] <= r_inflight_dest ? bus.data_out_D1 : bus.data_out_D0;
        r_buf_dest[r_wr_ptr] <= r_inflight_dest;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_deliver) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_deliver};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [cnt_width-1:0] r_cnt;
      always_ff @(posedge clk) begin
        if (!reset || w_hold_cnt) begin
          r_cnt <= '0;
        end else if (w_deliver && (r_buf_dest[r_rd_ptr] == (gi == 1))
                     && (r_cnt != {cnt_width{1'b1}})) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  endgenerate

  assign bus.D0_pop    = w_pop0;
  assign bus.D1_pop    = w_pop1;
  assign bus.out_valid = (r_occ != 2'd0);
  assign bus.out_data  = r_buf_data[r_rd_ptr];
  assign bus.out_dest  = r_buf_dest[r_rd_ptr];
  assign cnt_D0        = g_cnt[0].r_cnt;
  assign cnt_D1        = g_cnt[1].r_cnt;
  assign idle_out      = (r_state == S_IDLE);

endmodule

// File: tb/tb_dest_drain_arbiter.sv
// Drives dest_drain_arbiter from two queue-backed FIFOs and compares every cycle
// against a queue-level reference of the arbitration, buffering and counting rules.
module tb_dest_drain_arbiter;

  localparam int DW   = 6;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;
  localparam int M_IDLE = 0, M_ACTIVE = 1, M_INIT = 2;

  typedef struct {
    logic          dest;
    logic [DW-1:0] data;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          init;
  logic [CW-1:0] cnt_D0, cnt_D1;
  logic          idle_out;

  dest_drain_arbiter_if #(.data_width(DW)) bus ();

  dest_drain_arbiter #(.data_width(DW), .cnt_width(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .init     (init),
    .bus      (bus),
    .cnt_D0   (cnt_D0),
    .cnt_D1   (cnt_D1),
    .idle_out (idle_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [DW-1:0] q0[$], q1[$];
  ent_t m_buf[$], m_inf[$];
  int   m_state, m_cnt0, m_cnt1;
  logic m_last_d1;

  int   pop_log[$];      // 0 = D0 pop, 1 = D1 pop
  int   pop_cyc[$];
  ent_t del_log[$];
  int   valid_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_buf.delete();
    m_inf.delete();
    m_state   = M_IDLE;
    m_cnt0    = 0;
    m_cnt1    = 0;
    m_last_d1 = 1'b1;
  endtask

  task automatic clear_logs();
    pop_log.delete();
    pop_cyc.delete();
    del_log.delete();
    valid_cyc.delete();
  endtask

  task automatic push0(input logic [DW-1:0] v);
    q0.push_back(v);
    bus.empty_fifo_D0 = 1'b0;
  endtask

  task automatic push1(input logic [DW-1:0] v);
    q1.push_back(v);
    bus.empty_fifo_D1 = 1'b0;
  endtask

  // One clock: check at the falling edge, then apply FIFO pops and advance the model.
  task automatic cycle();
    bit   ne0, ne1, blk, del, ep0, ep1, hold, dp0, dp1, rst_n, in_init;
    int   load, nxt;
    ent_t pe, he;
    @(negedge clk);
    ne0     = (q0.size() > 0);
    ne1     = (q1.size() > 0);
    rst_n   = reset;
    in_init = init;
    hold    = in_init || (m_state == M_INIT);
    blk     = !rst_n || hold;
    del     = (m_buf.size() > 0) && bus.out_ready;
    load    = m_buf.size() + m_inf.size() - (del ? 1 : 0);
    ep0 = 1'b0;
    ep1 = 1'b0;
    if (!blk && load < 2) begin
      if (ne0 && (!ne1 || m_last_d1)) ep0 = 1'b1;
      else if (ne1) ep1 = 1'b1;
    end
    check("D0_pop", bus.D0_pop, ep0);
    check("D1_pop", bus.D1_pop, ep1);
    check("out_valid", bus.out_valid, m_buf.size() > 0);
    if (m_buf.size() > 0) begin
      he = m_buf[0];
      check("out_data", bus.out_data, he.data);
      check("out_dest", bus.out_dest, he.dest);
    end
    check("cnt_D0", cnt_D0, m_cnt0);
    check("cnt_D1", cnt_D1, m_cnt1);
    check("idle_out", idle_out, m_state == M_IDLE);
    dp0 = bus.D0_pop;
    dp1 = bus.D1_pop;
    if (dp0) begin pop_log.push_back(0); pop_cyc.push_back(cyc); end
    if (dp1) begin pop_log.push_back(1); pop_cyc.push_back(cyc); end
    if (bus.out_valid) valid_cyc.push_back(cyc);
    if (bus.out_valid && bus.out_ready) begin
      he.dest = bus.out_dest;
      he.data = bus.out_data;
      del_log.push_back(he);
    end
    pe.dest = ep1;
    pe.data = ep1 ? (ne1 ? q1[0] : '0) : (ne0 ? q0[0] : '0);

    @(posedge clk);
    #1;
    cyc++;
    if (dp0 && q0.size() > 0) bus.data_out_D0 = q0.pop_front();
    if (dp1 && q1.size() > 0) bus.data_out_D1 = q1.pop_front();
    bus.empty_fifo_D0 = (q0.size() == 0);
    bus.empty_fifo_D1 = (q1.size() == 0);

    if (!rst_n) begin
      model_clear();
    end else begin
      if (in_init) nxt = M_INIT;
      else if (m_state == M_INIT) nxt = M_IDLE;
      else if (m_state == M_IDLE) nxt = (ne0 || ne1) ? M_ACTIVE : M_IDLE;
      else nxt = (!ne0 && !ne1 && m_inf.size() == 0 && m_buf.size() == 0) ? M_IDLE : M_ACTIVE;
      if (del) begin
        he = m_buf.pop_front();
        if (!hold) begin
          if (he.dest == 1'b0 && m_cnt0 < CMAX) m_cnt0++;
          if (he.dest == 1'b1 && m_cnt1 < CMAX) m_cnt1++;
        end
      end
      if (hold) begin
        m_cnt0 = 0;
        m_cnt1 = 0;
      end
      if (m_inf.size() > 0) m_buf.push_back(m_inf.pop_front());
      if (ep0 || ep1) begin
        m_inf.push_back(pe);
        m_last_d1 = ep1;
      end
      m_state = nxt;
    end
    check("occupancy_le_2", m_buf.size() <= 2, 1'b1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    q0.delete();
    q1.delete();
    bus.empty_fifo_D0 = 1'b1;
    bus.empty_fifo_D1 = 1'b1;
    reset = 1'b0;
    run(2);
    reset = 1'b1;
    clear_logs();
  endtask

  initial begin
    int ih;
    reset             = 1'b0;
    init              = 1'b0;
    bus.out_ready     = 1'b0;
    bus.empty_fifo_D0 = 1'b1;
    bus.empty_fifo_D1 = 1'b1;
    bus.data_out_D0   = '0;
    bus.data_out_D1   = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    run(1);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_dest", bus.out_dest, 0);
    reset = 1'b1;
    clear_logs();

    // Single source, three words.
    bus.out_ready = 1'b1;
    push0(6'h11); push0(6'h12); push0(6'h13);
    run(8);
    check("t1_pops", pop_log.size(), 3);
    if (pop_cyc.size() == 3) check("t1_consecutive", pop_cyc[2] - pop_cyc[0], 2);
    if (pop_cyc.size() > 0 && valid_cyc.size() > 0)
      check("t1_latency", valid_cyc[0] - pop_cyc[0], 2);
    check("t1_ndel", del_log.size(), 3);
    for (int i = 0; i < 3 && i < del_log.size(); i++) check("t1_data", del_log[i].data, 6'h11 + i);
    check("t1_cnt_D0", cnt_D0, 3);
    check("t1_idle", idle_out, 1'b1);

    // Both sources, round-robin alternation.
    do_reset();
    bus.out_ready = 1'b1;
    push0(6'h01); push0(6'h02); push1(6'h21); push1(6'h22);
    run(10);
    check("t2_npops", pop_log.size(), 4);
    for (int i = 0; i < 4 && i < pop_log.size(); i++) check("t2_order", pop_log[i], i % 2);
    for (int i = 0; i < 4 && i < del_log.size(); i++) check("t2_dest", del_log[i].dest, i % 2);
    check("t2_cnt_D0", cnt_D0, 2);
    check("t2_cnt_D1", cnt_D1, 2);

    // Backpressure: two pops fill the buffer, then stall.
    do_reset();
    bus.out_ready = 1'b0;
    push0(6'h31); push0(6'h32); push0(6'h33); push0(6'h34);
    run(6);
    check("t3_stall_pops", pop_log.size(), 2);
    check("t3_head", bus.out_data, 6'h31);
    bus.out_ready = 1'b1;
    run(8);
    check("t3_npops", pop_log.size(), 4);
    check("t3_ndel", del_log.size(), 4);
    for (int i = 0; i < 4 && i < del_log.size(); i++) check("t3_data", del_log[i].data, 6'h31 + i);
    check("t3_cnt_D0", cnt_D0, 4);

    // init raised right after a D1 pop.
    do_reset();
    bus.out_ready = 1'b1;
    push1(6'h2a); push1(6'h2b);
    run(1);
    check("t4_first_pop", pop_log.size(), 1);
    init = 1'b1;
    run(5);
    check("t4_no_pops_in_init", pop_log.size(), 1);
    check("t4_inflight_delivered", del_log.size(), 1);
    if (del_log.size() > 0) check("t4_del_data", del_log[0].data, 6'h2a);
    check("t4_cnt_D1_init", cnt_D1, 0);
    init = 1'b0;
    run(8);
    check("t4_ndel", del_log.size(), 2);
    check("t4_cnt_D1", cnt_D1, 1);

    // Counter saturation.
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40; i++) push0(i[DW-1:0]);
    run(50);
    check("t5_ndel", del_log.size(), 40);
    check("t5_cnt_sat", cnt_D0, CMAX);

    // Reset while the buffer is full.
    do_reset();
    bus.out_ready = 1'b0;
    push0(6'h05); push0(6'h06); push0(6'h07);
    run(5);
    check("t6_full", bus.out_valid, 1'b1);
    reset = 1'b0;
    run(1);
    reset = 1'b1;
    check("t6_valid", bus.out_valid, 1'b0);
    check("t6_cnt", {cnt_D1, cnt_D0}, 0);
    check("t6_idle", idle_out, 1'b1);
    bus.out_ready = 1'b1;
    run(6);

    // Randomised traffic, backpressure, init pulses and occasional reset.
    ih = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0 && q0.size() < 8) push0(6'($urandom));
      if ($urandom_range(0, 2) == 0 && q1.size() < 8) push1(6'($urandom));
      bus.out_ready = ($urandom_range(0, 9) < 7);
      if (ih > 0) ih--;
      else if ($urandom_range(0, 39) == 0) ih = $urandom_range(1, 4);
      init  = (ih > 0);
      reset = ($urandom_range(0, 199) != 0);
      cycle();
    end
    reset = 1'b1;
    init  = 1'b0;
    bus.out_ready = 1'b1;
    run(40);
    check("rand_drained", bus.out_valid, 1'b0);
    check("rand_idle", idle_out, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dest_drain_arbiter.md
Name: dest_drain_arbiter

Overview:
Downstream consumer of the transmission-layer core's two destination FIFOs (D0, D1). It pops both FIFOs under round-robin arbitration and absorbs the 1-cycle FIFO read latency. It merges words into a single valid/ready output stream tagged with the source destination, and keeps per-destination delivered-word counters for the bench/link layer.

Parameters:
data_width, 6, word width of D0/D1 FIFO data and of out_data
cnt_width, 5, width of each delivered-word counter

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
init  input  1  level; while high, block is in INIT (no new pops, counters held at 0)
empty_fifo_D0  input  1  D0 FIFO empty flag
empty_fifo_D1  input  1  D1 FIFO empty flag
data_out_D0  input  data_width  D0 FIFO read data, valid 1 cycle after D0_pop
data_out_D1  input  data_width  D1 FIFO read data, valid 1 cycle after D1_pop
D0_pop  output  1  pop request to D0 FIFO
D1_pop  output  1  pop request to D1 FIFO
out_valid  output  1  out_data/out_dest hold a word
out_ready  input  1  sink accepts the word when out_valid && out_ready
out_data  output  data_width  head word
out_dest  output  1  0 = word came from D0, 1 = from D1
cnt_D0  output  cnt_width  words from D0 delivered since last init/reset
cnt_D1  output  cnt_width  words from D1 delivered since last init/reset
idle_out  output  1  high in IDLE state

Behaviour:
- Reset (reset==0 at an edge): state=IDLE, D0_pop=D1_pop=0, out_valid=0, out_data=0, out_dest=0, cnt_D0=cnt_D1=0, in-flight flag cleared, buffer occupancy 0, round-robin pointer = "D1 last" (so D0 wins the first tie). Reset mid-transfer drops any buffered/in-flight word.
- Clock and reset: single clock clk; reset is synchronous and active-low.
- FSM: IDLE, ACTIVE, INIT.
  - IDLE→ACTIVE when init==0 and either empty flag is 0.
  - ACTIVE→IDLE when both empty flags are 1, there is no in-flight pop, and the buffer is empty.
  - Any state→INIT when init==1. INIT→IDLE when init==0.
- Pops are combinational from registered state and current flags; at most one pop per cycle.
  - A pop is issued only in IDLE/ACTIVE, only when the target FIFO is non-empty, and only when (buffer occupancy + in-flight) < 2.
  - Back-to-back pops of the same FIFO are allowed; empty flags reflect all pops up to the previous edge.
- Arbitration:
  - If only one FIFO is non-empty, pop it.
  - If both are non-empty, pop the one not granted last.
  - The pointer updates only on an issued pop.
- Capture: a pop in cycle n registers data_out_Dx and the dest tag into the 2-entry output buffer at the edge ending cycle n+1. Pop-to-out_valid latency is 2 cycles when the buffer is empty.
- Output buffer: 2-entry FIFO, head drives out_data/out_dest, out_valid = occupancy>0.
  - Capture and delivery in the same cycle leave occupancy unchanged.
  - out_data/out_dest are stable while out_valid && !out_ready.
  - Overflow is impossible by the pop rule. The bench asserts that occupancy never exceeds 2.
- INIT:
  - No new pops are issued.
  - A word already in flight is still captured, and the buffer keeps draining to the sink.
  - cnt_D0/cnt_D1 are forced to 0 every cycle and do not count deliveries made during INIT.
- Counters: cnt_Dx increments on each delivery (out_valid && out_ready) with out_dest==x, outside INIT. Counters saturate at 2^cnt_width-1 (no wrap).
- idle_out = (state==IDLE), registered with the state.

Test Plan:
- Reset then only D0 non-empty with 3 words 0x11, 0x12, 0x13, out_ready=1 -> D0_pop high 3 consecutive cycles; out_valid from 2 cycles after the first pop; out_data 0x11, 0x12, 0x13, out_dest=0; cnt_D0=3; return to IDLE, idle_out=1.
- Both FIFOs hold 2 words (D0: 0x01, 0x02; D1: 0x21, 0x22) -> pop order D0, D1, D0, D1; out_dest 0, 1, 0, 1; cnt_D0=2, cnt_D1=2.
- out_ready=0 with D0 holding 4 words -> exactly 2 pops, then pops stall; out_data holds the first word. Raise out_ready -> remaining 2 popped; all 4 delivered in order with no loss or duplicate.
- init asserted the cycle after a D1 pop -> in-flight word captured and delivered; no further pops while init=1; cnt_D1 reads 0; after init drops, normal draining resumes from the IDLE state.
- 40 words from D0 with cnt_width=5 -> cnt_D0 saturates at 31.
- reset=0 while the buffer holds 2 words -> next cycle out_valid=0, counters 0, pops 0, state IDLE.
